// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_sequencer                                                          |
// | Turns one ALU request into the latch/compute/output command sequence and   |
// | returns the captured Y and flags on a valid/ready response port.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int FLAGW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [FLAGW-1:0] req_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [FLAGW-1:0] rsp_flags,
  output logic             rsp_err,
  output logic [3:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_dout,
  output logic             alu_doe,
  input  logic [WIDTH-1:0] alu_din
);

  localparam logic [3:0] c_op_adc = 4'h1;
  localparam logic [3:0] c_op_sbb = 4'h3;
  localparam logic [3:0] c_op_cmp = 4'h4;
  localparam logic [3:0] c_op_inc = 4'h5;
  localparam logic [3:0] c_op_dec = 4'h6;

  localparam logic [3:0] c_cmd_nop     = 4'd0;
  localparam logic [3:0] c_cmd_latcha  = 4'd1;
  localparam logic [3:0] c_cmd_latchb  = 4'd2;
  localparam logic [3:0] c_cmd_latchf  = 4'd3;
  localparam logic [3:0] c_cmd_latchop = 4'd4;
  localparam logic [3:0] c_cmd_outy    = 4'd5;
  localparam logic [3:0] c_cmd_outf    = 4'd6;
  localparam logic [3:0] c_cmd_compute = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_LA, S_LB, S_LF, S_LOP, S_CMPT, S_OY, S_OF, S_CAPF, S_RSP
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [FLAGW-1:0] r_flags;

  logic w_skip_b;
  logic w_use_f;
  logic w_is_cmp;

  assign w_skip_b = (r_op == c_op_inc) || (r_op == c_op_dec);
  assign w_use_f  = (r_op == c_op_adc) || (r_op == c_op_sbb);
  assign w_is_cmp = (r_op == c_op_cmp);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next_state = S_LA;
      S_LA:   w_next_state = w_skip_b ? S_LOP : S_LB;
      S_LB:   w_next_state = w_use_f ? S_LF : S_LOP;
      S_LF:   w_next_state = S_LOP;
      S_LOP:  w_next_state = S_CMPT;
      S_CMPT: w_next_state = w_is_cmp ? S_OF : S_OY;
      S_OY:   w_next_state = S_OF;
      S_OF:   w_next_state = S_CAPF;
      S_CAPF: w_next_state = S_RSP;
      S_RSP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      alu_cmd   <= c_cmd_nop;
      alu_dout  <= '0;
      alu_doe   <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_flags   <= '0;
    end else begin
      r_state   <= w_next_state;
      req_ready <= (w_next_state == S_IDLE);
      rsp_valid <= (w_next_state == S_RSP);
      alu_cmd   <= c_cmd_nop;
      alu_doe   <= 1'b0;
      alu_dout  <= '0;
      case (w_next_state)
        // LA is only ever entered from IDLE, so A comes straight off the request port.
        S_LA:   begin alu_cmd <= c_cmd_latcha;  alu_doe <= 1'b1; alu_dout <= req_a; end
        S_LB:   begin alu_cmd <= c_cmd_latchb;  alu_doe <= 1'b1; alu_dout <= r_b; end
        S_LF:   begin alu_cmd <= c_cmd_latchf;  alu_doe <= 1'b1; alu_dout <= WIDTH'(r_flags); end
        S_LOP:  begin alu_cmd <= c_cmd_latchop; alu_doe <= 1'b1; alu_dout <= WIDTH'(r_op); end
        S_CMPT: alu_cmd <= c_cmd_compute;
        S_OY:   alu_cmd <= c_cmd_outy;
        S_OF:   alu_cmd <= c_cmd_outf;
        default: ;
      endcase

      if (r_state == S_IDLE && req_valid) begin
        r_op    <= req_op;
        r_a     <= req_a;
        r_b     <= req_b;
        r_flags <= req_flags;
      end

      // The ALU bus answers one cycle after each output command.
      if (r_state == S_OF) begin
        rsp_y <= w_is_cmp ? '0 : alu_din;
      end
      if (r_state == S_CAPF) begin
        rsp_flags <= alu_din[FLAGW-1:0];
        rsp_err   <= alu_din[FLAGW-1];
      end
    end
  end

endmodule
`default_nettype wire
